// File: rtl/enemy_slot_mapper.sv
// enemy_slot_mapper
// Bridges one enemy-type controller onto a contiguous slot range of the shared
// enemy table. Positions and alive flags are snapshotted once per frame. Hits
// from the collision unit are decoded to local channels and queued as kill
// requests. A death-flash counter runs per channel.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_tick        one-cycle pulse at start of vblank
//   src_x/src_y       per-channel live coordinates (channel i at [i*COORD_W +: COORD_W])
//   src_alive         per-channel controller alive flags
//   enemy_x/enemy_y   frame-snapshotted coordinates for slot BASE_SLOT+i
//   enemy_alive       frame-snapshotted alive, masked by pending/handled kills
//   enemy_dying       death-flash active per channel
//   hit_valid/ready   hit handshake, hit_slot is the global slot number
//   kill_valid/ready  kill request handshake, kill_ch is the local channel
module enemy_slot_mapper #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned BASE_SLOT    = 21,
  parameter int unsigned SLOT_W       = 5,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DEATH_FRAMES = 8,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic [NUM_CH*COORD_W-1:0]  src_x,
  input  logic [NUM_CH*COORD_W-1:0]  src_y,
  input  logic [NUM_CH-1:0]          src_alive,
  output logic [NUM_CH*COORD_W-1:0]  enemy_x,
  output logic [NUM_CH*COORD_W-1:0]  enemy_y,
  output logic [NUM_CH-1:0]          enemy_alive,
  output logic [NUM_CH-1:0]          enemy_dying,
  input  logic                       hit_valid,
  input  logic [SLOT_W-1:0]          hit_slot,
  output logic                       hit_ready,
  output logic                       kill_valid,
  output logic [CH_W-1:0]            kill_ch,
  input  logic                       kill_ready
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_CH-1:0] kill_mask;
  logic [NUM_CH-1:0] kill_mask_next;
  logic [7:0]        dying_cnt      [NUM_CH];
  logic [7:0]        dying_cnt_next [NUM_CH];

  logic [CH_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic              fifo_empty;
  logic              fifo_full;
  logic              hit_accept;
  logic              in_range;
  logic [CH_W-1:0]   hit_ch;
  logic              push;
  logic              pop;

  // FIFO status and handshakes; a full queue stalls every hit, including discards
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign hit_ready  = ~rst & ~fifo_full;
  assign hit_accept = hit_valid & hit_ready;
  assign kill_valid = ~fifo_empty;
  assign kill_ch    = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign pop        = kill_valid & kill_ready;

  // Global slot to local channel decode, done at 32 bits to avoid wrap
  assign in_range = (32'(hit_slot) >= BASE_SLOT) && (32'(hit_slot) < (BASE_SLOT + NUM_CH));
  assign hit_ch   = CH_W'(32'(hit_slot) - BASE_SLOT);
  assign push     = hit_accept & in_range & ~kill_mask[hit_ch];

  // Per-channel mask and flash counter update; a new kill overrides the frame update
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      kill_mask_next[i] = kill_mask[i];
      dying_cnt_next[i] = dying_cnt[i];
      if (frame_tick) begin
        if (!src_alive[i]) kill_mask_next[i] = 1'b0;
        if (dying_cnt[i] != 8'd0) dying_cnt_next[i] = dying_cnt[i] - 8'd1;
      end
      if (push && (hit_ch == CH_W'(i))) begin
        kill_mask_next[i] = 1'b1;
        dying_cnt_next[i] = 8'(DEATH_FRAMES);
      end
    end
  end

  // State, snapshot and FIFO pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      kill_mask   <= '0;
      enemy_x     <= '0;
      enemy_y     <= '0;
      enemy_alive <= '0;
      enemy_dying <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) dying_cnt[i] <= 8'd0;
    end else begin
      kill_mask <= kill_mask_next;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        dying_cnt[i]   <= dying_cnt_next[i];
        enemy_dying[i] <= (dying_cnt_next[i] != 8'd0);
      end
      if (frame_tick) begin
        enemy_x     <= src_x;
        enemy_y     <= src_y;
        enemy_alive <= src_alive & ~kill_mask_next;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Queue storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= hit_ch;
  end

endmodule

// File: doc/enemy_slot_mapper.md
# enemy_slot_mapper

Parametrised bridge between one enemy-type controller (mosquito, fly, …) and a contiguous slot range of the shared enemy table read by the renderer and collision unit. Positions and alive flags are snapshotted once per frame so every consumer sees a frame-consistent view. Collision hits addressed by global slot number are translated back to local channel indices and queued as kill requests to the controller. Per-channel death-flash counters are also kept.

## Interface
- NUM_CH, 2, channels (entities) handled; 1..16
- BASE_SLOT, 21, global enemy slot of channel 0
- SLOT_W, 5, width of global slot index
- COORD_W, 10, coordinate width
- FIFO_DEPTH, 4, kill-request queue depth; power of two ≥ 2
- DEATH_FRAMES, 8, frames enemy_dying stays high after a kill; 1..255
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vblank
- src_x  in  NUM_CH*COORD_W  channel i at bits [i*COORD_W +: COORD_W]
- src_y  in  NUM_CH*COORD_W  same packing
- src_alive  in  NUM_CH  controller alive flags
- enemy_x  out  NUM_CH*COORD_W  snapshotted x, slot BASE_SLOT+i
- enemy_y  out  NUM_CH*COORD_W  snapshotted y
- enemy_alive  out  NUM_CH  snapshotted alive, kill-masked
- enemy_dying  out  NUM_CH  death-flash active
- hit_valid  in  1  collision unit reports a hit
- hit_slot  in  SLOT_W  global slot hit
- hit_ready  out  1  hit accepted when hit_valid & hit_ready
- kill_valid  out  1  kill request pending
- kill_ch  out  clog2(NUM_CH) (min 1)  local channel to kill
- kill_ready  in  1  controller consumes request when kill_valid & kill_ready

## Operation
- State per channel: kill_mask[i], dying_cnt[i] (8 bit). Shared: kill FIFO of channel indices.
- Snapshot on frame_tick: enemy_x/y[i] <= src_x/y[i]; enemy_alive[i] <= src_alive[i] & ~kill_mask_next[i]. Outputs hold between ticks.
- Hit decode on accept: in-range iff BASE_SLOT ≤ hit_slot < BASE_SLOT+NUM_CH; ch = hit_slot − BASE_SLOT.
  - Out of range: accepted and discarded, no state change.
  - In range, kill_mask[ch]=1: discarded (duplicate hit).
  - Otherwise: push ch into FIFO, set kill_mask[ch], load dying_cnt[ch]=DEATH_FRAMES.
- kill_mask[i] clears on frame_tick when src_alive[i]=0 (controller has despawned; slot reusable). Accepted hit on the same channel in the same cycle wins: mask stays set.
- dying_cnt decrements by 1 on each frame_tick, saturating at 0; a reload in the same cycle wins. enemy_dying[i] = (dying_cnt[i] != 0), registered.
- FIFO: kill_valid = not empty; kill_ch = head entry; pop on kill_valid & kill_ready. Order of kill requests = order of accepted hits.
- hit_ready = ~rst & (FIFO not full). No push while full, even when a pop occurs in the same cycle. Discarded hits are also stalled while full.

## Timing
- Reset (rst high at posedge): enemy_x/y/alive/dying = 0, kill_mask = 0, dying_cnt = 0, FIFO empty, kill_valid = 0, kill_ch = 0, hit_ready = 0. hit_ready = 1 in the first cycle after rst deasserts. Reset mid-operation drops queued kills without emitting them.
- Snapshot latency: outputs reflect src_* as sampled at the frame_tick edge, visible the cycle after.
- Hit→kill latency: hit accepted at edge N, kill_valid=1 from cycle N+1 when the FIFO was empty.
- Hit→enemy_alive low: at the next frame_tick edge; a hit coincident with frame_tick takes effect at that same tick.
- Hit→enemy_dying high: cycle N+1.
- Pop and push in the same cycle with FIFO non-full and non-empty: both occur; count unchanged.
- frame_tick with no hit or pop: only snapshot, mask clear and dying decrement occur.

## Test plan
- Reset then defaults, NUM_CH=2, BASE_SLOT=21: assert rst 3 cycles → all outputs 0; hit_ready=1 one cycle after release.
- Snapshot: src_x={200,100}, src_y={50,40}, alive=2'b11, then frame_tick → enemy_x[0]=100, enemy_x[1]=200, alive=11; change src without tick → outputs unchanged.
- Hit slot 22 at edge N → kill_valid=1, kill_ch=1 at N+1; enemy_dying[1]=1; next frame_tick → enemy_alive[1]=0 even though src_alive[1]=1; 8 further ticks → enemy_dying[1]=0.
- Duplicate and out-of-range hits: slot 22 twice, then slots 20 and 23 → exactly one kill request; no state change from 20 or 23.
- Backpressure: kill_ready=0, hits on slots 21/22 with masks cleared between them until 4 queued → hit_ready=0; raise kill_ready → kill_ch order matches hit order, hit_ready returns 1 after the first pop.
- Mask release: after kill of ch 0, src_alive[0]=0 at a frame_tick, then src_alive[0]=1 at the next tick → enemy_alive[0]=1; new hit on slot 21 is accepted. Assert rst with 2 queued → kill_valid=0 after the reset edge.
